// File: rtl/decode_stage_if.sv
// decode_stage_if: fetch, write-back and hazard inputs plus ID/EX outputs of the decode stage.
interface decode_stage_if;
  logic [31:0] instruction_dec, pc_dec, wb_data;
  logic        flush, wb_en, ex_mem_read, stall_fetch;
  logic [4:0]  wb_rd, ex_rd, rd_ex;
  logic [31:0] rs1_data_ex, rs2_data_ex, imm_ex, pc_ex_out;
  logic [3:0]  alu_op_ex;
  logic        reg_write_ex, mem_read_ex, mem_write_ex, branch_ex, jump_ex, rti_ex, rsi_ex;
  modport master (
    output instruction_dec, pc_dec, flush, wb_en, wb_rd, wb_data, ex_mem_read, ex_rd,
    input  stall_fetch, rs1_data_ex, rs2_data_ex, imm_ex, pc_ex_out, rd_ex, alu_op_ex,
           reg_write_ex, mem_read_ex, mem_write_ex, branch_ex, jump_ex, rti_ex, rsi_ex
  );
  modport slave (
    input  instruction_dec, pc_dec, flush, wb_en, wb_rd, wb_data, ex_mem_read, ex_rd,
    output stall_fetch, rs1_data_ex, rs2_data_ex, imm_ex, pc_ex_out, rd_ex, alu_op_ex,
           reg_write_ex, mem_read_ex, mem_write_ex, branch_ex, jump_ex, rti_ex, rsi_ex
  );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: RV32I decode, 32x32 register file, load-use stall and flush into ID/EX.
// Define DEC_WB_BYPASS_EN to forward a same-cycle write-back to register reads.
module decode_stage (
  input logic clk,
  input logic rst,
  decode_stage_if.slave d
);
  logic [31:0] rf [32];
  logic [31:0] ins, imm, rs1_data, rs2_data;
  logic [6:0]  opc;
  logic [4:0]  rs1, rs2, rd;
  logic [2:0]  f3;
  logic [3:0]  alu_op;
  logic is_r, is_i, is_ld, is_st, is_br, is_jal, is_lui, is_sys, rti, rsi;
  logic use1, use2, valid, wr, bubble;
  assign ins    = d.instruction_dec;
  assign opc    = ins[6:0];
  assign rd     = ins[11:7];
  assign f3     = ins[14:12];
  assign rs1    = ins[19:15];
  assign rs2    = ins[24:20];
  assign is_r   = opc == 7'b0110011;
  assign is_i   = opc == 7'b0010011;
  assign is_ld  = opc == 7'b0000011;
  assign is_st  = opc == 7'b0100011;
  assign is_br  = opc == 7'b1100011;
  assign is_jal = opc == 7'b1101111;
  assign is_lui = opc == 7'b0110111;
  assign is_sys = opc == 7'b1110011;
  assign rti    = is_sys && f3 == 3'b000 && ins[31:20] == 12'h302;
  assign rsi    = is_sys && f3 == 3'b000 && ins[31:20] == 12'h303;
  assign use1   = is_r | is_i | is_ld | is_st | is_br;
  assign use2   = is_r | is_st | is_br;
  assign wr     = is_r | is_i | is_ld | is_jal | is_lui;
  assign valid  = wr | is_st | is_br | rti | rsi;
  // Flush wins over the load-use stall, so a killed instruction never holds fetch.
  assign d.stall_fetch = !rst && !d.flush && d.ex_mem_read && d.ex_rd != 5'd0 &&
                         ((use1 && rs1 == d.ex_rd) || (use2 && rs2 == d.ex_rd));
  assign bubble = d.flush | d.stall_fetch | !valid;
  assign imm = is_st  ? {{20{ins[31]}}, ins[31:25], ins[11:7]} :
               is_br  ? {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0} :
               is_jal ? {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0} :
               is_lui ? {ins[31:12], 12'd0} :
                        {{20{ins[31]}}, ins[31:20]};
  assign alu_op = is_r  ? {ins[30], f3} :
                  is_i  ? {f3 == 3'b101 && ins[30], f3} :
                  is_br ? 4'b1000 : 4'b0000;
`ifdef DEC_WB_BYPASS_EN
  assign rs1_data = rs1 == 5'd0 ? '0 : (d.wb_en && d.wb_rd == rs1) ? d.wb_data : rf[rs1];
  assign rs2_data = rs2 == 5'd0 ? '0 : (d.wb_en && d.wb_rd == rs2) ? d.wb_data : rf[rs2];
`else
  assign rs1_data = rs1 == 5'd0 ? '0 : rf[rs1];
  assign rs2_data = rs2 == 5'd0 ? '0 : rf[rs2];
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < 32; i++) rf[i] <= '0;
    else if (d.wb_en && d.wb_rd != 5'd0) rf[d.wb_rd] <= d.wb_data;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      d.rs1_data_ex  <= '0;
      d.rs2_data_ex  <= '0;
      d.imm_ex       <= '0;
      d.pc_ex_out    <= '0;
      d.alu_op_ex    <= '0;
      d.rd_ex        <= '0;
      d.reg_write_ex <= 1'b0;
      d.mem_read_ex  <= 1'b0;
      d.mem_write_ex <= 1'b0;
      d.branch_ex    <= 1'b0;
      d.jump_ex      <= 1'b0;
      d.rti_ex       <= 1'b0;
      d.rsi_ex       <= 1'b0;
    end else begin
      d.rs1_data_ex  <= rs1_data;
      d.rs2_data_ex  <= rs2_data;
      d.imm_ex       <= imm;
      d.pc_ex_out    <= d.pc_dec;
      d.alu_op_ex    <= alu_op;
      d.rd_ex        <= (bubble || !wr) ? 5'd0 : rd;
      d.reg_write_ex <= !bubble && wr;
      d.mem_read_ex  <= !bubble && is_ld;
      d.mem_write_ex <= !bubble && is_st;
      d.branch_ex    <= !bubble && is_br;
      d.jump_ex      <= !bubble && is_jal;
      d.rti_ex       <= !bubble && rti;
      d.rsi_ex       <= !bubble && rsi;
    end
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed and random checks of decode_stage against an arithmetic reference model.
`timescale 1ns/1ps
module tb_decode_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  decode_stage_if d();
  decode_stage dut (.clk(clk), .rst(rst), .d(d));
  logic [31:0] regs [32];
  int checks = 0, failures = 0;
  logic e_stall, e_bub, e_wr, e_mr, e_mw, e_br, e_j, e_rti, e_rsi, e_u1, e_u2, e_has_imm;
  logic [4:0]  e_rd;
  logic [31:0] e_rs1, e_rs2, e_imm, e_pc;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic longint fld(input logic [31:0] x, input int lo, input int n);
    logic [31:0] m;
    m = (x >> lo) & ((32'd1 << n) - 32'd1);
    return longint'({32'd0, m});
  endfunction
  function automatic logic [31:0] sx(input longint v, input int bits);
    longint t;
    t = v;
    if (t >= (64'sd1 <<< (bits - 1))) t = t - (64'sd1 <<< bits);
    return t[31:0];
  endfunction
  function automatic logic [31:0] rdreg(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
`ifdef DEC_WB_BYPASS_EN
    if (d.wb_en && d.wb_rd == r) return d.wb_data;
`endif
    return regs[r];
  endfunction
  task automatic predict();
    logic [31:0] x;
    logic ok;
    int op, f3;
    longint i12;
    x = d.instruction_dec;
    op = int'(fld(x, 0, 7));
    f3 = int'(fld(x, 12, 3));
    i12 = fld(x, 20, 12);
    {e_u1, e_u2, e_wr, e_mr, e_mw, e_br, e_j, e_rti, e_rsi, e_has_imm} = '0;
    ok = 1'b1;
    e_imm = sx(i12, 12);
    case (op)
      51:  begin e_u1 = 1; e_u2 = 1; e_wr = 1; end
      19:  begin e_u1 = 1; e_wr = 1; e_has_imm = 1; end
      3:   begin e_u1 = 1; e_wr = 1; e_mr = 1; e_has_imm = 1; end
      35:  begin e_u1 = 1; e_u2 = 1; e_mw = 1; e_has_imm = 1;
                 e_imm = sx(fld(x, 25, 7) * 32 + fld(x, 7, 5), 12); end
      99:  begin e_u1 = 1; e_u2 = 1; e_br = 1; e_has_imm = 1;
                 e_imm = sx(fld(x, 31, 1) * 4096 + fld(x, 7, 1) * 2048 + fld(x, 25, 6) * 32 + fld(x, 8, 4) * 2, 13); end
      111: begin e_wr = 1; e_j = 1; e_has_imm = 1;
                 e_imm = sx(fld(x, 31, 1) * 1048576 + fld(x, 12, 8) * 4096 + fld(x, 20, 1) * 2048 + fld(x, 21, 10) * 2, 21); end
      55:  begin e_wr = 1; e_has_imm = 1; e_imm = sx(fld(x, 12, 20) * 4096, 33); end
      115: begin
             e_has_imm = 1;
             if (f3 == 0 && i12 == 770) e_rti = 1;
             else if (f3 == 0 && i12 == 771) e_rsi = 1;
             else ok = 0;
           end
      default: ok = 0;
    endcase
    e_stall = !d.flush && d.ex_mem_read && d.ex_rd != 5'd0 &&
              ((e_u1 && x[19:15] == d.ex_rd) || (e_u2 && x[24:20] == d.ex_rd));
    e_bub = !ok || d.flush || e_stall;
    if (e_bub) {e_wr, e_mr, e_mw, e_br, e_j, e_rti, e_rsi} = '0;
    e_rd = e_wr ? x[11:7] : 5'd0;
    e_rs1 = rdreg(x[19:15]);
    e_rs2 = rdreg(x[24:20]);
    e_pc = d.pc_dec;
  endtask
  task automatic cycle();
    predict();
    #1;
    chk("stall_fetch", d.stall_fetch, e_stall);
    @(posedge clk);
    #1;
    if (d.wb_en && d.wb_rd != 5'd0) regs[d.wb_rd] = d.wb_data;
    chk("reg_write_ex", d.reg_write_ex, e_wr);
    chk("mem_read_ex", d.mem_read_ex, e_mr);
    chk("mem_write_ex", d.mem_write_ex, e_mw);
    chk("branch_ex", d.branch_ex, e_br);
    chk("jump_ex", d.jump_ex, e_j);
    chk("rti_ex", d.rti_ex, e_rti);
    chk("rsi_ex", d.rsi_ex, e_rsi);
    chk("rd_ex", d.rd_ex, e_rd);
    if (!e_bub) begin
      chk("pc_ex_out", d.pc_ex_out, e_pc);
      if (e_u1) chk("rs1_data_ex", d.rs1_data_ex, e_rs1);
      if (e_u2) chk("rs2_data_ex", d.rs2_data_ex, e_rs2);
      if (e_has_imm) chk("imm_ex", d.imm_ex, e_imm);
    end
  endtask
  task automatic check_zero(input string tag);
    chk({tag, "_stall"}, d.stall_fetch, 0);
    chk({tag, "_rs1"}, d.rs1_data_ex, 0);
    chk({tag, "_rs2"}, d.rs2_data_ex, 0);
    chk({tag, "_imm"}, d.imm_ex, 0);
    chk({tag, "_pc"}, d.pc_ex_out, 0);
    chk({tag, "_rd"}, d.rd_ex, 0);
    chk({tag, "_alu"}, d.alu_op_ex, 0);
    chk({tag, "_ctl"}, {d.reg_write_ex, d.mem_read_ex, d.mem_write_ex, d.branch_ex,
                        d.jump_ex, d.rti_ex, d.rsi_ex}, 0);
  endtask
  task automatic idle(input logic [31:0] ins, input logic [31:0] pc);
    d.instruction_dec = ins;
    d.pc_dec = pc;
    d.flush = 0;
    d.wb_en = 0;
    d.wb_rd = 0;
    d.wb_data = 0;
    d.ex_mem_read = 0;
    d.ex_rd = 0;
  endtask
  function automatic logic [31:0] rtype(input logic [4:0] rs2, rs1, rd);
    return {7'd0, rs2, rs1, 3'd0, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] addi(input logic [11:0] im, input logic [4:0] rs1, rd);
    return {im, rs1, 3'd0, rd, 7'b0010011};
  endfunction
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic [6:0] ops [10] = '{7'd51, 7'd19, 7'd3, 7'd35, 7'd99, 7'd111, 7'd55, 7'd115, 7'd115, 7'd127};
  logic [31:0] x;
  int k;
  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'd0;
    idle(addi(12'd1, 5'd5, 5'd7), 32'h100);
    d.ex_mem_read = 1;
    d.ex_rd = 5'd5;
    #12;
    check_zero("reset");
    @(negedge clk);
    rst = 0;
    idle(NOP, 32'h104);
    d.wb_en = 1; d.wb_rd = 5'd5; d.wb_data = 32'hAA;
    cycle();
    idle(rtype(5'd5, 5'd5, 5'd6), 32'h108);
    cycle();
    chk("add_rs1", d.rs1_data_ex, 32'hAA);
    chk("add_rs2", d.rs2_data_ex, 32'hAA);
    chk("add_rd", d.rd_ex, 5'd6);
    idle(addi(12'd1, 5'd5, 5'd7), 32'h10C);
    d.ex_mem_read = 1; d.ex_rd = 5'd5;
    cycle();
    d.ex_mem_read = 0;
    cycle();
    chk("ldu_imm", d.imm_ex, 32'd1);
    chk("ldu_rw", d.reg_write_ex, 1);
    d.ex_mem_read = 1; d.ex_rd = 5'd5; d.flush = 1;
    cycle();
    idle(32'h3020_0073, 32'h110);
    cycle();
    idle(32'h3030_0073, 32'h114);
    cycle();
    idle(32'hFFFF_FFFF, 32'h118);
    cycle();
    idle(NOP, 32'h11C);
    d.wb_en = 1; d.wb_rd = 5'd0; d.wb_data = 32'h1234;
    cycle();
    idle(rtype(5'd0, 5'd0, 5'd1), 32'h120);
    cycle();
    chk("x0_read", d.rs1_data_ex, 32'd0);
    idle(rtype(5'd9, 5'd9, 5'd10), 32'h124);
    d.wb_en = 1; d.wb_rd = 5'd9; d.wb_data = 32'h55;
    cycle();
    for (int n = 0; n < 400; n++) begin
      k = $urandom_range(0, 9);
      x = $urandom;
      x[6:0] = ops[k];
      if (k == 8) begin
        x[14:12] = 3'd0;
        x[31:20] = $urandom_range(0, 1) ? 12'h302 : 12'h303;
      end
      idle(x, $urandom);
      d.ex_mem_read = $urandom_range(0, 2) == 0;
      d.ex_rd = $urandom_range(0, 1) ? x[19:15] : 5'($urandom);
      d.flush = $urandom_range(0, 7) == 0;
      d.wb_en = 1'($urandom);
      d.wb_rd = 5'($urandom);
      d.wb_data = $urandom;
      cycle();
    end
    idle(addi(12'd1, 5'd5, 5'd7), 32'h200);
    d.ex_mem_read = 1; d.ex_rd = 5'd5;
    #1;
    chk("pre_rst_stall", d.stall_fetch, 1);
    #1;
    rst = 1;
    #1;
    check_zero("async_rst");
    for (int i = 0; i < 32; i++) regs[i] = 32'd0;
    #2;
    rst = 0;
    d.ex_mem_read = 0;
    cycle();
    chk("post_rst_pc", d.pc_ex_out, 32'h200);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 instruction_dec  input  32  instruction from fetch stage.
REQ-004 pc_dec  input  32  PC paired with instruction_dec.
REQ-005 flush  input  1  branch taken in execute; kill the instruction in decode.
REQ-006 wb_en, wb_rd[4:0], wb_data[31:0]  input  1/5/32  write-back port.
REQ-007 ex_mem_read, ex_rd[4:0]  input  1/5  load currently in execute and its destination.
REQ-008 stall_fetch  output  1  combinational; fetch holds PC and instruction_dec while high.
REQ-009 rs1_data_ex, rs2_data_ex, imm_ex, pc_ex_out  output  32 each  ID/EX operands.
REQ-010 rd_ex[4:0], alu_op_ex[3:0]  output  destination register and ALU select.
REQ-011 reg_write_ex, mem_read_ex, mem_write_ex, branch_ex, jump_ex, rti_ex, rsi_ex  output  1 each  ID/EX control.

Function
REQ-012 Register file: 32x32; x0 reads 0; writes to x0 ignored; synchronous write on wb_en.
REQ-013 Decode of RV32I opcodes: 0110011 R, 0010011 I-ALU, 0000011 load, 0100011 store, 1100011 branch, 1101111 JAL, 0110111 LUI, 1110011 SYSTEM.
REQ-014 Immediates: I, S, B, J and U formats, sign-extended to 32 bits; B/J bit 0 = 0.
REQ-015 SYSTEM, funct3=0, imm=0x302 -> rti_ex=1; imm=0x303 -> rsi_ex=1; any other SYSTEM encoding -> bubble.
REQ-016 Unrecognised opcode -> bubble: all control outputs 0, rd_ex=0.
REQ-017 Latency: one cycle; decoded fields appear on the ID/EX outputs after the rising edge following acceptance.
REQ-018 Load-use hazard: stall_fetch=1 when ex_mem_read=1, ex_rd!=0, and ex_rd equals a source register actually used by the instruction.
REQ-019 rs1 is used by R, I-ALU, load, store and branch; rs2 is used by R, store and branch.
REQ-020 During a stall, ID/EX receives a bubble and the decode input is held by fetch; the instruction re-decodes on the next cycle.
REQ-021 flush=1 -> ID/EX receives a bubble on the next edge, and stall_fetch is forced to 0.
REQ-022 flush takes priority over stall.
REQ-023 Bubble definition: the reg_write, mem_read, mem_write, branch, jump, rti and rsi fields all 0; data fields unspecified but stable.
REQ-024 rti_ex and rsi_ex each assert for exactly one cycle per decoded instruction; they are never asserted simultaneously.
REQ-025 pc_ex_out carries pc_dec unchanged; immediate and PC arithmetic are performed in execute.

Reset
REQ-026 While rst=1, every ID/EX output is 0, all 32 registers are 0, and stall_fetch is 0.
REQ-027 rst asserted mid-stall or mid-flush immediately clears state; the first post-reset edge decodes instruction_dec normally.

Configuration
REQ-028 Macro DEC_WB_BYPASS_EN. When defined, a read of register r in the same cycle as a write with wb_en=1 and wb_rd=r (r!=0) returns wb_data.
REQ-029 When DEC_WB_BYPASS_EN is undefined, that read returns the previously stored value; software guarantees the spacing.

Verification
REQ-030 Write x5=0x0000_00AA via WB, then decode ADD x6,x5,x5 -> rs1_data_ex=rs2_data_ex=0xAA, rd_ex=6, reg_write_ex=1.
REQ-031 ex_mem_read=1, ex_rd=5, decode ADDI x7,x5,1 -> stall_fetch=1 for one cycle and a bubble; next cycle imm_ex=1, reg_write_ex=1.
REQ-032 flush=1 together with that load-use hazard -> stall_fetch=0, bubble issued, no rti/rsi/reg_write.
REQ-033 Decode SYSTEM imm=0x302 -> rti_ex=1 for one cycle. Decode SYSTEM imm=0x303 -> rsi_ex=1 for one cycle. Decode 0xFFFFFFFF -> bubble.
REQ-034 WB to x0 with 0x1234, then read x0 -> 0. Same-cycle WB x9=0x55 and read x9 -> 0x55 with the macro defined, old value without it.
REQ-035 Assert rst during a stall -> all outputs 0 asynchronously; after release, pc_ex_out=pc_dec on the next edge.
